rvm_lsu: RTL



---
 rtl/rvm_lsu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rvm_lsu.sv
// rvm_lsu: data-side load/store sequencer for the multi-cycle core.
// Aligns lanes, extends loads, reports misalignment, bus errors and stalls.
module rvm_lsu #(
  parameter int STALL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_start,
  input  logic        lsu_store,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_error,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic        mem_w_en,
  output logic [3:0]  mem_b_en,
  input  logic        mem_error,
  input  logic        mem_stall
);

  localparam int CW =
    (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           r_store, r_uns;
  logic [1:0]     r_size;
  logic [31:0]    r_addr, r_wdata;
  logic [31:0]    rdata_q, rdata_n;
  logic           mis_q, mis_n;
  logic           err_q, err_n;
  logic           accept;
  logic           bad;
  logic           acc;
  logic [3:0]     be;
  logic [31:0]    wd;
  logic [31:0]    shifted;
  logic [31:0]    load_val;

  assign bad = (lsu_size == 2'b11) ||
               (lsu_size == 2'b01 && lsu_addr[0]) ||
               (lsu_size == 2'b10 && lsu_addr[1:0] != 2'b00);

  assign acc     = (state == ACCESS);
  assign shifted = mem_rdata >> {r_addr[1:0], 3'b000};

  // Lane enables and replicated store data for the latched request.
  always_comb begin
    be = 4'b1111;
    wd = r_wdata;
    unique case (r_size)
      2'b00: begin
        be = 4'b0001 << r_addr[1:0];
        wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << r_addr[1:0];
        wd = {2{r_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = r_wdata;
      end
    endcase
  end

  // Extract the addressed lane and sign/zero extend it.
  always_comb begin
    load_val = shifted;
    unique case (r_size)
      2'b00: load_val = r_uns ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_val = r_uns ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign mem_c_en  = acc;
  assign mem_w_en  = acc & r_store;
  assign mem_addr  = acc ? {r_addr[31:2], 2'b00} : 32'b0;
  assign mem_b_en  = acc ? be : 4'b0;
  assign mem_wdata = (acc & r_store) ? wd : 32'b0;

  assign lsu_busy       = (state != IDLE);
  assign lsu_done       = (state == RESP);
  assign lsu_rdata      = rdata_q;
  assign lsu_misaligned = mis_q;
  assign lsu_error      = err_q;

  // Next state, stall watchdog and result capture.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    mis_n   = mis_q;
    err_n   = err_q;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu_start) begin
          accept  = 1'b1;
          rdata_n = 32'b0;
          err_n   = 1'b0;
          mis_n   = bad;
          cnt_n   = '0;
          state_n = bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_stall) begin
          cnt_n = cnt + 1'b1;
          if (STALL_TIMEOUT != 0 && cnt_n == TO) begin
            state_n = RESP;
            err_n   = 1'b1;
            rdata_n = 32'b0;
          end
        end else begin
          state_n = RESP;
          err_n   = mem_error;
          rdata_n = (r_store || mem_error) ? 32'b0 : load_val;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= 32'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      mis_q   <= mis_n;
      err_q   <= err_n;
    end
  end

  // Request fields, captured only when a start is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_store <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'b0;
      r_wdata <= 32'b0;
    end else if (accept) begin
      r_store <= lsu_store;
      r_size  <= lsu_size;
      r_uns   <= lsu_unsigned;
      r_addr  <= lsu_addr;
      r_wdata <= lsu_wdata;
    end
  end

endmodule
